// File: rtl/dc_readback_tx_pkg.sv
// Shared definitions for the DC readback transmit path: frame states, header
// layout and the running checksum step.
package dc_readback_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CHAN,
    ST_COUNT,
    ST_LOAD,
    ST_BYTE,
    ST_CSUM,
    ST_DONE
  } tx_state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Header layout: SYNC, CHAN, COUNT, then payload words MSB-first.
  localparam int HDR_SYNC_POS   = 0;
  localparam int HDR_CHAN_POS   = 1;
  localparam int HDR_COUNT_POS  = 2;
  localparam int HDR_BYTES      = 3;
  localparam int BYTES_PER_WORD = 4;

  // COUNT value that tells the host the requested channel does not exist.
  localparam logic [7:0] COUNT_NACK = 8'h00;

  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/dc_readback_tx_serializer.sv
// Splits one 32-bit register word into four bytes, most significant byte first,
// advancing one byte each time the consumer accepts the current one.
module dc_readback_tx_serializer
  import dc_readback_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_advance,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [31:0] word_reg;
  logic [1:0]  cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      word_reg <= '0;
      cnt_reg  <= '0;
    end else if (i_load) begin
      word_reg <= i_word;
      cnt_reg  <= '0;
    end else if (i_advance) begin
      word_reg <= {word_reg[23:0], 8'h00};
      cnt_reg  <= cnt_reg + 2'd1;
    end
  end

  assign o_byte = word_reg[31:24];
  assign o_last = (cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/dc_readback_tx.sv
// Serialises one DC channel's register bank into a checksummed byte frame
// and feeds it into the UART TX FIFO, stalling whenever the FIFO is full.
module dc_readback_tx
  import dc_readback_tx_pkg::*;
#(
  parameter int         DAC_CHANNEL = 24,
  parameter int         FRAME_WORDS = 32,
  parameter int         CHAN_WIDTH  = 5,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_req,
  input  logic [CHAN_WIDTH-1:0]          i_req_chan,
  output logic [CHAN_WIDTH-1:0]          o_rd_chan,
  output logic [$clog2(FRAME_WORDS)-1:0] o_rd_idx,
  input  logic [31:0]                    i_rd_data,
  output logic                           o_txq_enq,
  output logic [7:0]                     o_txq_data,
  input  logic                           i_txq_full,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int IDX_W = $clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  tx_state_e             state_reg, state_next;
  logic [CHAN_WIDTH-1:0] chan_reg, chan_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  valid_reg, valid_next;
  logic [7:0]            csum_reg, csum_next;

  logic       ser_load;
  logic       ser_advance;
  logic [7:0] ser_byte;
  logic       ser_last;

  dc_readback_tx_serializer u_ser (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (ser_load),
    .i_word    (i_rd_data),
    .i_advance (ser_advance),
    .o_byte    (ser_byte),
    .o_last    (ser_last)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= ST_IDLE;
      chan_reg  <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      csum_reg  <= '0;
    end else begin
      state_reg <= state_next;
      chan_reg  <= chan_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      csum_reg  <= csum_next;
    end
  end

  // Every emitting state offers its byte only while the FIFO has room, and
  // advances solely on that accepted cycle.
  always_comb begin
    state_next  = state_reg;
    chan_next   = chan_reg;
    idx_next    = idx_reg;
    valid_next  = valid_reg;
    csum_next   = csum_reg;
    o_txq_enq   = 1'b0;
    o_txq_data  = 8'h00;
    ser_load    = 1'b0;
    ser_advance = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_req) begin
          state_next = ST_SYNC;
          chan_next  = i_req_chan;
          valid_next = (int'(i_req_chan) < DAC_CHANNEL);
          idx_next   = '0;
          csum_next  = '0;
        end
      end
      ST_SYNC: begin
        o_txq_data = SYNC_BYTE;
        o_txq_enq  = !i_txq_full;
        if (!i_txq_full) state_next = ST_CHAN;
      end
      ST_CHAN: begin
        o_txq_data = 8'(chan_reg);
        o_txq_enq  = !i_txq_full;
        if (!i_txq_full) begin
          csum_next  = csum_step(csum_reg, o_txq_data);
          state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        o_txq_data = valid_reg ? 8'(FRAME_WORDS) : COUNT_NACK;
        o_txq_enq  = !i_txq_full;
        if (!i_txq_full) begin
          csum_next  = csum_step(csum_reg, o_txq_data);
          state_next = valid_reg ? ST_LOAD : ST_CSUM;
        end
      end
      ST_LOAD: begin
        ser_load   = 1'b1;
        state_next = ST_BYTE;
      end
      ST_BYTE: begin
        o_txq_data  = ser_byte;
        o_txq_enq   = !i_txq_full;
        ser_advance = !i_txq_full;
        if (!i_txq_full) begin
          csum_next = csum_step(csum_reg, o_txq_data);
          if (ser_last) begin
            if (idx_reg == LAST_IDX) begin
              state_next = ST_CSUM;
            end else begin
              idx_next   = idx_reg + 1'b1;
              state_next = ST_LOAD;
            end
          end
        end
      end
      ST_CSUM: begin
        o_txq_data = csum_reg;
        o_txq_enq  = !i_txq_full;
        if (!i_txq_full) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_rd_chan = chan_reg;
  assign o_rd_idx  = idx_reg;
  assign o_busy    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign o_done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_dc_readback_tx.sv
// Scoreboard bench for dc_readback_tx: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every enqueued byte.
module tb_dc_readback_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [4:0]  req_chan = 5'd0;
  logic [4:0]  rd_chan;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic        enq;
  logic [7:0]  data;
  logic        txq_full = 1'b0;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit rand_full = 1'b0;
  bit hold_full = 1'b0;

  always #5 clk = ~clk;

  dc_readback_tx dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_req      (req),
    .i_req_chan (req_chan),
    .o_rd_chan  (rd_chan),
    .o_rd_idx   (rd_idx),
    .i_rd_data  (rd_data),
    .o_txq_enq  (enq),
    .o_txq_data (data),
    .i_txq_full (txq_full),
    .o_busy     (busy),
    .o_done     (done)
  );

  // Register store: channel 3 holds C0DE_0000+k, other channels a distinct pattern.
  assign rd_data = (rd_chan == 5'd3) ? (32'hC0DE_0000 + 32'(rd_idx))
                                     : (32'hBAD0_0000 + 32'({rd_chan, rd_idx}));

  always @(posedge clk) begin
    #1;
    txq_full = hold_full | (rand_full & 1'($urandom_range(0, 1)));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (txq_full) check("enq_while_full", 32'(enq), 32'd0);
    if (enq) begin
      acc_cnt++;
      rx_q.push_back(data);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %h expected none", data);
      end else begin
        check("byte", 32'(data), 32'(exp_q.pop_front()));
      end
    end
    if (done) done_cnt++;
  end

  // Checksum hand-computed: data bytes XOR to 0 (1E repeated 32x, 0..31), so 03^20 = 23.
  task automatic push_chan3();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h20);
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back(8'hC0);
      exp_q.push_back(8'hDE);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(k));
    end
    exp_q.push_back(8'h23);
  endtask

  task automatic push_invalid24();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h18);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h18);
  endtask

  task automatic send_req(input logic [4:0] c);
    @(posedge clk); #1;
    req = 1'b1;
    req_chan = c;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no o_done expected o_done within %0d cycles", budget);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // RX-packer view: bytes 3..130 regroup MSB-first into the 32 bank words.
  task automatic loopback_check();
    logic [31:0] w;
    check("frame_len", 32'(rx_q.size()), 32'd132);
    if (rx_q.size() == 132) begin
      for (int k = 0; k < 32; k++) begin
        w = {rx_q[3+4*k], rx_q[4+4*k], rx_q[5+4*k], rx_q[6+4*k]};
        check("loopback_word", w, 32'hC0DE_0000 + 32'(k));
      end
    end
  endtask

  initial begin
    int d0;
    int a0;
    int base;
    bit hit;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_enq", 32'(enq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_chan", 32'(rd_chan), 32'd0);
    check("rst_rd_idx", 32'(rd_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: channel 3, no backpressure
    push_chan3();
    rx_q.delete();
    d0 = done_cnt;
    send_req(5'd3);
    check("t1_first_enq", 32'(enq), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(400);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    loopback_check();

    // 2: invalid channel 24 gets a NACK frame
    push_invalid24();
    send_req(5'd24);
    wait_done(50);
    check("t2_rd_idx", 32'(rd_idx), 32'd0);
    check("t2_rd_chan", 32'(rd_chan), 32'd24);
    repeat (3) @(posedge clk);

    // 3: random backpressure plus a long stall
    push_chan3();
    rx_q.delete();
    d0 = done_cnt;
    rand_full = 1'b1;
    send_req(5'd3);
    repeat (40) @(posedge clk);
    #1;
    hold_full = 1'b1;
    a0 = acc_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("t3_stall_no_bytes", 32'(acc_cnt), 32'(a0));
    check("t3_stall_busy", 32'(busy), 32'd1);
    hold_full = 1'b0;
    wait_done(2000);
    rand_full = 1'b0;
    repeat (5) @(posedge clk);
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);
    loopback_check();

    // 4: request while busy is dropped; new request right after o_done accepted
    push_chan3();
    send_req(5'd3);
    repeat (20) @(posedge clk);
    #1;
    req = 1'b1;
    req_chan = 5'd7;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done(400);
    @(posedge clk); #1;
    push_invalid24();
    req = 1'b1;
    req_chan = 5'd24;
    @(posedge clk); #1;
    req = 1'b0;
    check("t4_req_after_done", 32'(busy), 32'd1);
    wait_done(50);
    repeat (3) @(posedge clk);

    // 5: reset after two bytes of word 5, then a clean frame
    push_chan3();
    base = acc_cnt;
    send_req(5'd3);
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk);
      if (acc_cnt == base + 25) hit = 1'b1;
    end
    check("t5_reached_word5", 32'(hit), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_enq", 32'(enq), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rd_idx", 32'(rd_idx), 32'd0);
    check("t5_rst_rd_chan", 32'(rd_chan), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_chan3();
    rx_q.delete();
    send_req(5'd3);
    wait_done(400);
    loopback_check();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
